preadder_mt_pair: RTL and testbench

//  Parametrised multi-thread pre-adder in front of the polynomial multiplier.

---
 rtl/preadder_mt_pair.sv | 197 +++++++++++++++++++
 tb/tb_preadder_mt_pair.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preadder_mt_pair.sv
// Multi-thread coefficient-wise pre-adder feeding the polynomial multiplier.
// Each thread can hold a first pair beat until its matching second beat arrives.
module preadder_mt_pair #(
  parameter int unsigned  N_THREADS = 4,
  parameter int unsigned  N_COEF    = 3,
  parameter int unsigned  W         = 36,
  parameter int unsigned  LATENCY   = 2,
  parameter logic [W-1:0] SUB_BIAS  = {1'b1, {(W-1){1'b0}}},
  localparam int unsigned TW        = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [TW-1:0]          in_tid,
  input  logic [1:0]             in_mode,
  input  logic [N_COEF*W-1:0]    in_x,
  input  logic [N_COEF*W-1:0]    in_y,
  output logic                   out_valid,
  output logic [TW-1:0]          out_tid,
  output logic [N_COEF*W-1:0]    out_z0,
  output logic [N_COEF*W-1:0]    out_z1,
  output logic                   out_ovf,
  output logic                   err_pair
);

  localparam int unsigned DW = N_COEF * W;

  localparam logic [1:0] MODE_PASS     = 2'b00;
  localparam logic [1:0] MODE_ADDSUB   = 2'b01;
  localparam logic [1:0] MODE_PAIR_ADD = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_HELD = 1'b1} state_e;

  state_e        state_q [N_THREADS];
  state_e        state_d [N_THREADS];
  logic [DW-1:0] hx_q    [N_THREADS];
  logic [DW-1:0] hx_d    [N_THREADS];
  logic [DW-1:0] hy_q    [N_THREADS];
  logic [DW-1:0] hy_d    [N_THREADS];
  logic [1:0]    hmode_q [N_THREADS];
  logic [1:0]    hmode_d [N_THREADS];

  logic          tid_ok_c;
  logic          emit_c;
  logic          err_c;
  logic [DW-1:0] sel_hx_c;
  logic [DW-1:0] sel_hy_c;
  logic [DW-1:0] z0_c;
  logic [DW-1:0] z1_c;
  logic          ovf_c;
  logic [W:0]    r0_c;
  logic [W:0]    r1_c;

  logic          vld_q [LATENCY];
  logic [TW-1:0] tid_q [LATENCY];
  logic [DW-1:0] z0_q  [LATENCY];
  logic [DW-1:0] z1_q  [LATENCY];
  logic          ovf_q [LATENCY];
  logic          err_q;

  // {carry, sum} of a+b
  function automatic logic [W:0] add_c(input logic [W-1:0] a, input logic [W-1:0] b);
    return (W+1)'(a) + (W+1)'(b);
  endfunction

  // {borrow, a-b+SUB_BIAS}; borrow when a+SUB_BIAS < b
  function automatic logic [W:0] sub_b(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    t = (W+1)'(a) + (W+1)'(SUB_BIAS);
    return {(t < (W+1)'(b)), W'(t - (W+1)'(b))};
  endfunction

  // Per-thread pairing FSM: decides hold / emit / violation for the incoming beat
  always_comb begin : thread_next
    tid_ok_c = ({1'b0, in_tid} < (TW+1)'(N_THREADS));
    err_c    = in_valid && !tid_ok_c;
    emit_c   = 1'b0;
    sel_hx_c = '0;
    sel_hy_c = '0;
    for (int unsigned t = 0; t < N_THREADS; t++) begin
      state_d[t] = state_q[t];
      hx_d[t]    = hx_q[t];
      hy_d[t]    = hy_q[t];
      hmode_d[t] = hmode_q[t];
      if (in_valid && tid_ok_c && (in_tid == TW'(t))) begin
        if ((state_q[t] == ST_HELD) && (in_mode == hmode_q[t])) begin
          emit_c     = 1'b1;
          sel_hx_c   = hx_q[t];
          sel_hy_c   = hy_q[t];
          state_d[t] = ST_IDLE;
        end else begin
          // A mismatched beat drops the held one and is then treated as fresh
          if (state_q[t] == ST_HELD) err_c = 1'b1;
          if (in_mode[1]) begin
            state_d[t] = ST_HELD;
            hx_d[t]    = in_x;
            hy_d[t]    = in_y;
            hmode_d[t] = in_mode;
          end else begin
            state_d[t] = ST_IDLE;
            emit_c     = 1'b1;
          end
        end
      end
    end
  end

  // Coefficient-wise result for whichever beat emits this cycle
  always_comb begin : datapath
    z0_c  = '0;
    z1_c  = '0;
    ovf_c = 1'b0;
    r0_c  = '0;
    r1_c  = '0;
    for (int unsigned i = 0; i < N_COEF; i++) begin
      case (in_mode)
        MODE_PASS: begin
          r0_c = {1'b0, in_x[i*W +: W]};
          r1_c = {1'b0, in_y[i*W +: W]};
        end
        MODE_ADDSUB: begin
          r0_c = add_c(in_x[i*W +: W], in_y[i*W +: W]);
          r1_c = sub_b(in_x[i*W +: W], in_y[i*W +: W]);
        end
        MODE_PAIR_ADD: begin
          r0_c = add_c(sel_hx_c[i*W +: W], in_x[i*W +: W]);
          r1_c = add_c(sel_hy_c[i*W +: W], in_y[i*W +: W]);
        end
        default: begin
          r0_c = add_c(sel_hx_c[i*W +: W], in_x[i*W +: W]);
          r1_c = sub_b(sel_hx_c[i*W +: W], in_x[i*W +: W]);
        end
      endcase
      z0_c[i*W +: W] = r0_c[W-1:0];
      z1_c[i*W +: W] = r1_c[W-1:0];
      ovf_c          = ovf_c | r0_c[W] | r1_c[W];
    end
  end

  always_ff @(posedge clk) begin : thread_regs
    if (rst) begin
      for (int unsigned t = 0; t < N_THREADS; t++) begin
        state_q[t] <= ST_IDLE;
        hx_q[t]    <= '0;
        hy_q[t]    <= '0;
        hmode_q[t] <= 2'b00;
      end
    end else begin
      for (int unsigned t = 0; t < N_THREADS; t++) begin
        state_q[t] <= state_d[t];
        hx_q[t]    <= hx_d[t];
        hy_q[t]    <= hy_d[t];
        hmode_q[t] <= hmode_d[t];
      end
    end
  end

  // Result pipeline; payload only moves with its valid so outputs hold when idle
  always_ff @(posedge clk) begin : pipe_regs
    if (rst) begin
      err_q <= 1'b0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        vld_q[s] <= 1'b0;
        tid_q[s] <= '0;
        z0_q[s]  <= '0;
        z1_q[s]  <= '0;
        ovf_q[s] <= 1'b0;
      end
    end else begin
      err_q    <= err_c;
      vld_q[0] <= emit_c;
      if (emit_c) begin
        tid_q[0] <= in_tid;
        z0_q[0]  <= z0_c;
        z1_q[0]  <= z1_c;
        ovf_q[0] <= ovf_c;
      end
      for (int unsigned s = 1; s < LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          tid_q[s] <= tid_q[s-1];
          z0_q[s]  <= z0_q[s-1];
          z1_q[s]  <= z1_q[s-1];
          ovf_q[s] <= ovf_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_tid   = tid_q[LATENCY-1];
  assign out_z0    = z0_q[LATENCY-1];
  assign out_z1    = z1_q[LATENCY-1];
  assign out_ovf   = ovf_q[LATENCY-1];
  assign err_pair  = err_q;

endmodule

// File: tb/tb_preadder_mt_pair.sv
// Bench for preadder_mt_pair: directed scenarios plus random beats against a
// queue-based reference model of the pairing and arithmetic rules.
module tb_preadder_mt_pair;

  localparam int unsigned NT  = 4;
  localparam int unsigned NC  = 3;
  localparam int unsigned W   = 36;
  localparam int unsigned LAT = 2;
  localparam int unsigned DW  = NC * W;
  localparam logic [63:0] BIAS = 64'(1) << 35;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [1:0]    in_tid = '0;
  logic [1:0]    in_mode = '0;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_y = '0;
  logic          out_valid;
  logic [1:0]    out_tid;
  logic [DW-1:0] out_z0;
  logic [DW-1:0] out_z1;
  logic          out_ovf;
  logic          err_pair;

  preadder_mt_pair #(
    .N_THREADS(NT), .N_COEF(NC), .W(W), .LATENCY(LAT), .SUB_BIAS(36'h8_0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tid(in_tid), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_tid(out_tid),
    .out_z0(out_z0), .out_z1(out_z1), .out_ovf(out_ovf), .err_pair(err_pair)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [1:0]    tid;
    logic [DW-1:0] z0;
    logic [DW-1:0] z1;
    logic          ovf;
  } exp_t;

  exp_t          exp_q[$];
  bit            held  [NT];
  logic [DW-1:0] mhx   [NT];
  logic [DW-1:0] mhy   [NT];
  logic [1:0]    mmode [NT];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  logic          exp_err = 1'b0;
  logic [1:0]    last_tid = '0;
  logic [DW-1:0] last_z0 = '0;
  logic [DW-1:0] last_z1 = '0;
  logic          last_ovf = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // One coefficient: plain integer add, or subtract with bias
  function automatic void coef_op(input bit is_sub, input logic [35:0] a, input logic [35:0] b,
                                  output logic [35:0] z, output bit f);
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] s;
    a64 = {28'b0, a};
    b64 = {28'b0, b};
    if (!is_sub) begin
      s = a64 + b64;
      z = s[35:0];
      f = (s >= (64'(1) << 36));
    end else begin
      s = a64 + BIAS - b64;
      z = s[35:0];
      f = ((a64 + BIAS) < b64);
    end
  endfunction

  // Result of an emitting beat; (ax,ay) is the held beat for pair modes
  function automatic exp_t make_result(input int due, input logic [1:0] tid, input logic [1:0] mode,
                                       input logic [DW-1:0] ax, input logic [DW-1:0] ay,
                                       input logic [DW-1:0] bx, input logic [DW-1:0] by);
    exp_t e;
    logic [35:0] z;
    bit f;
    e.due = due;
    e.tid = tid;
    e.z0 = '0;
    e.z1 = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < int'(NC); i++) begin
      case (mode)
        2'b00: begin
          e.z0[i*36 +: 36] = bx[i*36 +: 36];
          e.z1[i*36 +: 36] = by[i*36 +: 36];
        end
        2'b01: begin
          coef_op(1'b0, bx[i*36 +: 36], by[i*36 +: 36], z, f); e.z0[i*36 +: 36] = z; e.ovf |= f;
          coef_op(1'b1, bx[i*36 +: 36], by[i*36 +: 36], z, f); e.z1[i*36 +: 36] = z; e.ovf |= f;
        end
        2'b10: begin
          coef_op(1'b0, ax[i*36 +: 36], bx[i*36 +: 36], z, f); e.z0[i*36 +: 36] = z; e.ovf |= f;
          coef_op(1'b0, ay[i*36 +: 36], by[i*36 +: 36], z, f); e.z1[i*36 +: 36] = z; e.ovf |= f;
        end
        default: begin
          coef_op(1'b0, ax[i*36 +: 36], bx[i*36 +: 36], z, f); e.z0[i*36 +: 36] = z; e.ovf |= f;
          coef_op(1'b1, ax[i*36 +: 36], bx[i*36 +: 36], z, f); e.z1[i*36 +: 36] = z; e.ovf |= f;
        end
      endcase
    end
    return e;
  endfunction

  task automatic model_beat(input bit v, input int tid, input logic [1:0] mode,
                            input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_err = 1'b0;
    if (!v) return;
    if (held[tid] && (mmode[tid] == mode)) begin
      exp_q.push_back(make_result(cyc + int'(LAT) - 1, 2'(tid), mode, mhx[tid], mhy[tid], x, y));
      held[tid] = 1'b0;
    end else begin
      if (held[tid]) exp_err = 1'b1;
      held[tid] = 1'b0;
      if (mode[1]) begin
        held[tid]  = 1'b1;
        mhx[tid]   = x;
        mhy[tid]   = y;
        mmode[tid] = mode;
      end else begin
        exp_q.push_back(make_result(cyc + int'(LAT) - 1, 2'(tid), mode, '0, '0, x, y));
      end
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("err_pair", DW'(err_pair), DW'(exp_err));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("out_valid", DW'(out_valid), DW'(1));
      chk("out_tid", DW'(out_tid), DW'(e.tid));
      chk("out_z0", out_z0, e.z0);
      chk("out_z1", out_z1, e.z1);
      chk("out_ovf", DW'(out_ovf), DW'(e.ovf));
      last_tid = e.tid;
      last_z0  = e.z0;
      last_z1  = e.z1;
      last_ovf = e.ovf;
    end else begin
      chk("out_valid_idle", DW'(out_valid), DW'(0));
      chk("hold_tid", DW'(out_tid), DW'(last_tid));
      chk("hold_z0", out_z0, last_z0);
      chk("hold_z1", out_z1, last_z1);
      chk("hold_ovf", DW'(out_ovf), DW'(last_ovf));
    end
  endtask

  task automatic step(input bit v, input int tid, input int mode,
                      input logic [DW-1:0] x, input logic [DW-1:0] y);
    in_valid = v;
    in_tid   = 2'(tid);
    in_mode  = 2'(mode);
    in_x     = x;
    in_y     = y;
    @(posedge clk);
    cyc++;
    #1;
    model_beat(v, tid, 2'(mode), x, y);
    check_outputs();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    for (int t = 0; t < int'(NT); t++) held[t] = 1'b0;
    exp_q.delete();
    exp_err  = 1'b0;
    last_tid = '0;
    last_z0  = '0;
    last_z1  = '0;
    last_ovf = 1'b0;
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_err", DW'(err_pair), DW'(0));
    chk("rst_tid", DW'(out_tid), DW'(0));
    chk("rst_z0", out_z0, '0);
    chk("rst_z1", out_z1, '0);
    chk("rst_ovf", DW'(out_ovf), DW'(0));
  endtask

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    logic [63:0]   r;
    for (int i = 0; i < int'(NC); i++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       v[i*36 +: 36] = '1;
        1:       v[i*36 +: 36] = 36'h8_0000_0000;
        2:       v[i*36 +: 36] = '0;
        default: v[i*36 +: 36] = r[35:0];
      endcase
    end
    return v;
  endfunction

  task automatic idle();
    step(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd_vec(), rnd_vec());
  endtask

  initial begin
    do_reset();
    do_reset();

    // 1: ADDSUB tid1
    step(1'b1, 1, 1, {3{36'd5}}, {3{36'd3}});
    idle();
    chk("t1_z0", out_z0, {3{36'd8}});
    chk("t1_z1", out_z1, {3{36'h8_0000_0002}});
    idle();

    // 2: pair on tid0 with a PASS on tid2 interleaved
    step(1'b1, 0, 2, {3{36'd1}}, {3{36'd2}});
    step(1'b1, 2, 0, rnd_vec(), rnd_vec());
    step(1'b1, 0, 2, {3{36'd10}}, {3{36'd20}});
    idle();
    chk("t2_z1", out_z1, {3{36'd22}});
    idle();

    // 3: PAIR_XSUB borrow
    step(1'b1, 3, 3, '0, rnd_vec());
    step(1'b1, 3, 3, {3{36'h8_0000_0001}}, rnd_vec());
    idle();
    chk("t3_z1", out_z1, {3{36'hF_FFFF_FFFF}});
    chk("t3_ovf", DW'(out_ovf), DW'(1));
    idle();

    // 4: mode violation, then a fresh pair on tid1
    step(1'b1, 1, 2, rnd_vec(), rnd_vec());
    step(1'b1, 1, 1, rnd_vec(), rnd_vec());
    step(1'b1, 1, 2, rnd_vec(), rnd_vec());
    step(1'b1, 1, 2, rnd_vec(), rnd_vec());
    idle();
    idle();

    // 5: reset drops held first beats
    step(1'b1, 0, 2, rnd_vec(), rnd_vec());
    step(1'b1, 1, 2, rnd_vec(), rnd_vec());
    do_reset();
    step(1'b1, 0, 2, rnd_vec(), rnd_vec());
    step(1'b1, 1, 2, rnd_vec(), rnd_vec());
    idle();
    step(1'b1, 0, 2, rnd_vec(), rnd_vec());
    step(1'b1, 1, 2, rnd_vec(), rnd_vec());
    idle();
    idle();

    // 6: back-to-back random beats, all-ones ADDSUB, then mixed random traffic
    for (int n = 0; n < 16; n++)
      step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd_vec(), rnd_vec());
    step(1'b1, 2, 1, '1, '1);
    idle();
    chk("t6_ovf", DW'(out_ovf), DW'(1));
    for (int n = 0; n < 300; n++)
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           rnd_vec(), rnd_vec());
    for (int n = 0; n < int'(LAT) + 2; n++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
